mem_arbiter: RTL and testbench

- Two-requester arbiter/sequencer in front of the shared 256-bit line memory. Port 0 is the I-cache; port 1 is the D-cache.
- Grants one line transaction at a time, round-robin on ties.
- Latches address, rw and write data for the granted requester.
- Drives the memory request for a programmable number of cycles to model latency, issues exactly one write-enable window, captures read data and returns a one-cycle ready pulse to the winner.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences one line transaction at a time onto a
// shared 256-bit line memory, modelling a fixed latency and stalling on mem_ready.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    output logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rw_q, mem_rw_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pick1;

    // Next-state: arbitration and latching in IDLE, latency count and stall in BUSY
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rw_d     = mem_rw_q;
        rdata_d      = rdata_q;
        pick1        = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time goes first
                if (req0_valid && req1_valid) begin
                    pick1 = ~last_grant_q;
                end else begin
                    pick1 = req1_valid;
                end
                if (req0_valid || req1_valid) begin
                    state_d      = BUSY;
                    cnt_d        = CNT_INIT;
                    last_grant_d = pick1;
                    grant_d      = pick1 ? 2'b10 : 2'b01;
                    mem_addr_d   = pick1 ? req1_addr  : req0_addr;
                    mem_wdata_d  = pick1 ? req1_wdata : req0_wdata;
                    mem_rw_d     = pick1 ? req1_rw    : req0_rw;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (mem_ready) begin
                    if (!mem_rw_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State register; reset outranks any completion in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rw_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rw_q     <= mem_rw_d;
            rdata_q      <= rdata_d;
        end
    end

    // Write enable only in the last BUSY cycle, repeated harmlessly while stalled
    assign mem_rw     = mem_rw_q & (state_q == BUSY) & (cnt_q == 4'd0);
    assign mem_valid  = (state_q == BUSY);
    assign busy       = (state_q != IDLE);
    assign grant      = grant_q;
    assign req0_ready = (state_q == DONE) & grant_q[0];
    assign req1_ready = (state_q == DONE) & grant_q[1];
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written stall,
// reset-abort and dropped-valid sequences against a small line-memory model.
module tb_mem_arbiter;

    localparam logic [255:0] L1 = 256'h11111111222222223333333344444444555555556666666677777777_88888888;
    localparam logic [255:0] L2 = 256'h22222222333333334444444455555555666666667777777788888888_99999999;
    localparam logic [255:0] P  = {8{32'hDEADBEEF}};
    localparam logic [255:0] P2 = {8{32'hCAFEF00D}};
    localparam logic [255:0] Q  = {8{32'h0BADF00D}};
    localparam logic [31:0]  A  = 32'h00014024;
    localparam logic [31:0]  B  = 32'h0001C024;
    localparam logic [31:0]  W  = 32'h00000040;
    localparam logic [31:0]  X  = 32'h00000080;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_rw, req0_ready;
    logic [31:0]  req0_addr;
    logic [255:0] req0_wdata;
    logic         req1_valid, req1_rw, req1_ready;
    logic [31:0]  req1_addr;
    logic [255:0] req1_wdata;
    logic [255:0] rdata, mem_wdata, mem_rdata;
    logic [31:0]  mem_addr;
    logic         mem_rw, mem_valid, mem_ready, busy;
    logic [1:0]   grant;

    logic [255:0] mem [0:65535];
    logic         pl_en;
    logic [15:0]  pl_addr;
    logic [255:0] pl_data;

    int checks = 0;
    int errors = 0;
    int rw_cnt;
    int rw_first;

    typedef struct {
        logic         rst_n;
        logic         v0, rw0;
        logic [31:0]  a0;
        logic         v1, rw1;
        logic [31:0]  a1;
        logic         busy;
        logic [1:0]   grant;
        logic         mv, mrw, r0, r1;
        logic [255:0] rd;
    } vec_t;

    vec_t tbl[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(256), .LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[15:0]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_rw) mem[mem_addr[15:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input logic rs, input logic v0, input logic rw0,
                       input logic [31:0] a0, input logic v1, input logic rw1,
                       input logic [31:0] a1, input logic bz, input logic [1:0] g,
                       input logic mv, input logic mrw, input logic r0, input logic r1,
                       input logic [255:0] rd);
        vec_t v;
        v.rst_n = rs; v.v0 = v0; v.rw0 = rw0; v.a0 = a0; v.v1 = v1; v.rw1 = rw1; v.a1 = a1;
        v.busy = bz; v.grant = g; v.mv = mv; v.mrw = mrw; v.r0 = r0; v.r1 = r1; v.rd = rd;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; pl_en = 1'b0; pl_addr = 16'h0; pl_data = '0;
        req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = 32'h0; req0_wdata = {32{8'h5A}};
        req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = 32'h0; req1_wdata = P;

        pl_en = 1'b1; pl_addr = A[15:0]; pl_data = L1; step();
        pl_addr = B[15:0]; pl_data = L2; step();
        pl_addr = W[15:0]; pl_data = '0; step();
        pl_en = 1'b0;
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_grant", 256'(grant), 256'(2'b00));
        chk("rst_mem_valid", 256'(mem_valid), 256'(1'b0));
        chk("rst_mem_rw", 256'(mem_rw), 256'(1'b0));
        chk("rst_ready", 256'({req1_ready, req0_ready}), 256'(2'b00));
        chk("rst_rdata", rdata, '0);
        chk("rst_mem_addr", 256'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        rst_n = 1'b1;
        step();

        // single read by port 0
        add(1, 1, 1, 0, A, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, '0);
        add(4, 1, 1, 0, A, 0, 0, 0, 1, 2'b01, 1, 0, 0, 0, '0);
        add(1, 1, 1, 0, A, 0, 0, 0, 1, 2'b01, 0, 0, 1, 0, L1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, L1);
        // tie after port 0 won last: port 1 first, then port 0
        add(1, 1, 1, 0, A, 1, 0, B, 0, 2'b00, 0, 0, 0, 0, L1);
        add(4, 1, 1, 0, A, 1, 0, B, 1, 2'b10, 1, 0, 0, 0, L1);
        add(1, 1, 1, 0, A, 1, 0, B, 1, 2'b10, 0, 0, 0, 1, L2);
        add(1, 1, 1, 0, A, 0, 0, B, 0, 2'b00, 0, 0, 0, 0, L2);
        add(4, 1, 1, 0, A, 0, 0, 0, 1, 2'b01, 1, 0, 0, 0, L2);
        add(1, 1, 1, 0, A, 0, 0, 0, 1, 2'b01, 0, 0, 1, 0, L1);
        // reset, then tie from reset: port 0 first, port 1 second
        add(1, 0, 1, 0, A, 1, 0, B, 0, 2'b00, 0, 0, 0, 0, L1);
        add(1, 1, 1, 0, A, 1, 0, B, 0, 2'b00, 0, 0, 0, 0, '0);
        add(4, 1, 1, 0, A, 1, 0, B, 1, 2'b01, 1, 0, 0, 0, '0);
        add(1, 1, 1, 0, A, 1, 0, B, 1, 2'b01, 0, 0, 1, 0, L1);
        add(1, 1, 0, 0, 0, 1, 0, B, 0, 2'b00, 0, 0, 0, 0, L1);
        add(4, 1, 0, 0, 0, 1, 0, B, 1, 2'b10, 1, 0, 0, 0, L1);
        add(1, 1, 0, 0, 0, 1, 0, B, 1, 2'b10, 0, 0, 0, 1, L2);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, L2);
        // port 1 writes P to 0x40, then port 0 reads it back
        add(1, 1, 0, 0, 0, 1, 1, W, 0, 2'b00, 0, 0, 0, 0, L2);
        add(3, 1, 0, 0, 0, 1, 1, W, 1, 2'b10, 1, 0, 0, 0, L2);
        add(1, 1, 0, 0, 0, 1, 1, W, 1, 2'b10, 1, 1, 0, 0, L2);
        add(1, 1, 0, 0, 0, 1, 1, W, 1, 2'b10, 0, 0, 0, 1, L2);
        add(1, 1, 1, 0, W, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, L2);
        add(4, 1, 1, 0, W, 0, 0, 0, 1, 2'b01, 1, 0, 0, 0, L2);
        add(1, 1, 1, 0, W, 0, 0, 0, 1, 2'b01, 0, 0, 1, 0, P);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, P);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n;
            req0_valid = tbl[i].v0; req0_rw = tbl[i].rw0; req0_addr = tbl[i].a0;
            req1_valid = tbl[i].v1; req1_rw = tbl[i].rw1; req1_addr = tbl[i].a1;
            mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_busy", i), 256'(busy), 256'(tbl[i].busy));
            chk($sformatf("v%0d_grant", i), 256'(grant), 256'(tbl[i].grant));
            chk($sformatf("v%0d_mem_valid", i), 256'(mem_valid), 256'(tbl[i].mv));
            chk($sformatf("v%0d_mem_rw", i), 256'(mem_rw), 256'(tbl[i].mrw));
            chk($sformatf("v%0d_ready0", i), 256'(req0_ready), 256'(tbl[i].r0));
            chk($sformatf("v%0d_ready1", i), 256'(req1_ready), 256'(tbl[i].r1));
            chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rd);
            step();
        end
        chk("wr_line_0x40", mem[16'h0040], P);

        // read stalled three cycles at cnt==0: ready moves to cycle 8
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = A; req1_valid = 1'b0; mem_ready = 1'b0;
        step();
        for (int c = 1; c <= 7; c++) begin
            mem_ready = (c == 7) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk($sformatf("stall_rd_c%0d_valid", c), 256'(mem_valid), 256'(1'b1));
            chk($sformatf("stall_rd_c%0d_ready", c), 256'(req0_ready), 256'(1'b0));
            step();
        end
        @(negedge clk);
        chk("stall_rd_ready", 256'(req0_ready), 256'(1'b1));
        chk("stall_rd_rdata", rdata, L1);
        req0_valid = 1'b0;
        step();

        // write stalled three cycles: mem_rw high from cycle 4 for four cycles
        req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = X; req0_wdata = P2; mem_ready = 1'b1;
        rw_cnt = 0; rw_first = 0;
        step();
        for (int c = 1; c <= 8; c++) begin
            mem_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (mem_rw) begin
                rw_cnt++;
                if (rw_first == 0) rw_first = c;
            end
            if (c == 8) begin
                chk("stall_wr_ready", 256'(req0_ready), 256'(1'b1));
                req0_valid = 1'b0;
            end
            step();
        end
        chk("stall_wr_rw_cycles", 256'(rw_cnt), 256'(4));
        chk("stall_wr_rw_first", 256'(rw_first), 256'(4));
        chk("stall_wr_line", mem[X[15:0]], P2);
        chk("stall_wr_rdata_kept", rdata, L1);

        // reset in cycle 2 of a write to 0x40 aborts it
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = W; req1_wdata = Q; rw_cnt = 0;
        step();
        @(negedge clk);
        if (mem_rw) rw_cnt++;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        if (mem_rw) rw_cnt++;
        chk("abort_busy_c2", 256'(busy), 256'(1'b1));
        step();
        rst_n = 1'b1; req1_valid = 1'b0;
        @(negedge clk);
        if (mem_rw) rw_cnt++;
        chk("abort_busy", 256'(busy), 256'(1'b0));
        chk("abort_grant", 256'(grant), 256'(2'b00));
        chk("abort_rdata", rdata, '0);
        chk("abort_mem_addr", 256'(mem_addr), '0);
        chk("abort_mem_valid", 256'(mem_valid), 256'(1'b0));
        chk("abort_rw_cycles", 256'(rw_cnt), 256'(0));
        chk("abort_line_0x40", mem[16'h0040], P);
        step();
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = A;
        req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = B;
        step();
        @(negedge clk);
        chk("post_rst_tie_grant", 256'(grant), 256'(2'b01));
        step(); step(); step(); step();
        @(negedge clk);
        chk("post_rst_ready0", 256'(req0_ready), 256'(1'b1));
        chk("post_rst_rdata", rdata, L1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // port 0 drops valid in cycle 2; transaction still completes
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = B;
        step();
        step();
        req0_valid = 1'b0;
        step(); step(); step();
        @(negedge clk);
        chk("drop_ready0", 256'(req0_ready), 256'(1'b1));
        chk("drop_ready1", 256'(req1_ready), 256'(1'b0));
        chk("drop_rdata", rdata, L2);
        step();
        @(negedge clk);
        chk("drop_idle", 256'(busy), 256'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
